// File: rtl/hp_vpu_pkg.sv
// Shared VPU types: instruction-queue entry and its parity helper.
package hp_vpu_pkg;

  localparam int VPU_ID_W = 4;

  typedef struct packed {
    logic [31:0]         instr;
    logic [VPU_ID_W-1:0] id;
    logic [31:0]         rs1;
    logic [31:0]         rs2;
  } iq_entry_t;

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic iq_parity(input iq_entry_t e);
    return ^e;
  endfunction

endpackage

// File: rtl/hp_vpu_iq_ram.sv
// Queue storage: synchronous write, asynchronous read. The contents are never
// reset, so this module can be swapped for a LUTRAM primitive.
module hp_vpu_iq_ram #(
  parameter int DEPTH = 8,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hp_vpu_iq_rv.sv
// VPU instruction queue with ready/valid on both sides and a registered
// first-word-fall-through head. The head register counts toward DEPTH; the RAM
// holds the entries behind it.
// Optional build macro: HP_VPU_IQ_PARITY_EN adds per-entry even parity, a
// check on head load, and the par_err_o output.
module hp_vpu_iq_rv
  import hp_vpu_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ID_W      = 4,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                in_instr_i,
  input  logic [ID_W-1:0]            in_id_i,
  input  logic [31:0]                in_rs1_i,
  input  logic [31:0]                in_rs2_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_instr_o,
  output logic [ID_W-1:0]            out_id_o,
  output logic [31:0]                out_rs1_o,
  output logic [31:0]                out_rs2_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
`ifdef HP_VPU_IQ_PARITY_EN
  output logic                       par_err_o,
`endif
  output logic                       almost_full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = $bits(iq_entry_t);
`ifdef HP_VPU_IQ_PARITY_EN
  localparam int RW = EW + 1;
`else
  localparam int RW = EW;
`endif

  logic [CW-1:0] count_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          head_vld_q;
  iq_entry_t     head_q, in_ent, rd_ent;
  logic [RW-1:0] wr_data, rd_data;
  logic          push, pop, head_free, ram_empty, load_ram, load_byp, ram_we;

  assign in_ent = '{instr: in_instr_i, id: VPU_ID_W'(in_id_i),
                    rs1: in_rs1_i, rs2: in_rs2_i};

  assign in_ready_o = (count_q < CW'(DEPTH));
  // A flush discards any push in the same cycle, so nothing is written.
  assign push       = in_valid_i & in_ready_o & ~flush_i;
  assign pop        = head_vld_q & out_ready_i;
  assign head_free  = ~head_vld_q | pop;
  // The RAM never holds DEPTH entries, so pointer equality means empty.
  assign ram_empty  = (wr_ptr_q == rd_ptr_q);
  // Head refills from the RAM first; a push only bypasses into the head when
  // nothing older is waiting, which keeps FIFO order.
  assign load_ram   = head_free & ~ram_empty;
  assign load_byp   = head_free & ram_empty & push;
  assign ram_we     = push & ~load_byp;

`ifdef HP_VPU_IQ_PARITY_EN
  logic par_bad, par_err_q;
  assign wr_data   = {iq_parity(in_ent), in_ent};
  assign rd_ent    = rd_data[EW-1:0];
  assign par_bad   = rd_data[RW-1] ^ iq_parity(rd_ent);
  assign par_err_o = par_err_q;

  // Parity error flag: one-cycle pulse on the cycle a corrupted entry is first shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       par_err_q <= 1'b0;
    else if (flush_i) par_err_q <= 1'b0;
    else              par_err_q <= load_ram & par_bad;
  end
`else
  assign wr_data = in_ent;
  assign rd_ent  = rd_data;
`endif

  hp_vpu_iq_ram #(.DEPTH(DEPTH), .W(RW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data)
  );

  // Occupancy, pointers and the head register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
    end else if (flush_i) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      head_vld_q <= 1'b0;
    end else begin
      count_q <= count_q + CW'(push) - CW'(pop);
      if (ram_we)   wr_ptr_q <= wr_ptr_q + PW'(1);
      if (load_ram) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (load_ram) begin
        head_q     <= rd_ent;
        head_vld_q <= 1'b1;
      end else if (load_byp) begin
        head_q     <= in_ent;
        head_vld_q <= 1'b1;
      end else if (pop) begin
        head_vld_q <= 1'b0;
      end
    end
  end

  assign out_valid_o   = head_vld_q;
  assign out_instr_o   = head_q.instr;
  assign out_id_o      = ID_W'(head_q.id);
  assign out_rs1_o     = head_q.rs1;
  assign out_rs2_o     = head_q.rs2;
  assign count_o       = count_q;
  assign almost_full_o = (count_q >= CW'(AF_THRESH));
  assign empty_o       = (count_q == '0);

endmodule

// File: tb/tb_hp_vpu_iq_rv.sv
// Bench for hp_vpu_iq_rv: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based reference model.
module tb_hp_vpu_iq_rv;
  import hp_vpu_pkg::*;

  localparam int DEPTH = 8;
  localparam int ID_W  = 4;
  localparam int AF    = DEPTH - 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0, rst_n = 1'b0;
  logic flush = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_rs1 = '0, in_rs2 = '0;
  logic [ID_W-1:0] in_id = '0, out_id;
  logic [31:0] out_instr, out_rs1, out_rs2;
  logic [CW-1:0] count;
  logic almost_full, empty;
`ifdef HP_VPU_IQ_PARITY_EN
  logic par_err;
`endif

  int checks = 0, errors = 0;
  iq_entry_t q[$];
  logic exp_perr = 1'b0;

  always #5 clk = ~clk;

  hp_vpu_iq_rv #(.DEPTH(DEPTH), .ID_W(ID_W), .AF_THRESH(AF)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_instr_i(in_instr), .in_id_i(in_id), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_instr_o(out_instr), .out_id_o(out_id), .out_rs1_o(out_rs1), .out_rs2_o(out_rs2),
    .count_o(count),
`ifdef HP_VPU_IQ_PARITY_EN
    .par_err_o(par_err),
`endif
    .almost_full_o(almost_full), .empty_o(empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every observable output against the model's view of the queue.
  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 64'(count), 64'(n));
    chk("in_ready", 64'(in_ready), 64'(n < DEPTH));
    chk("almost_full", 64'(almost_full), 64'(n >= AF));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("out_valid", 64'(out_valid), 64'(n > 0));
    if (n > 0) begin
      chk("instr", 64'(out_instr), 64'(q[0].instr));
      chk("id", 64'(out_id), 64'(q[0].id));
      chk("rs1", 64'(out_rs1), 64'(q[0].rs1));
      chk("rs2", 64'(out_rs2), 64'(q[0].rs2));
    end
`ifdef HP_VPU_IQ_PARITY_EN
    chk("par_err", 64'(par_err), 64'(exp_perr));
`endif
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [ID_W-1:0] id,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic ordy, input logic fl);
    in_valid = v; in_instr = ins; in_id = id; in_rs1 = r1; in_rs2 = r2;
    out_ready = ordy; flush = fl;
  endtask

  // One clock: decide handshakes from the model state, advance the model, check.
  task automatic step();
    bit push, pop;
    iq_entry_t e;
    push = in_valid && (q.size() < DEPTH);
    pop  = out_ready && (q.size() > 0);
    e = '{instr: in_instr, id: in_id, rs1: in_rs1, rs2: in_rs2};
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic push_id(input int id, input logic ordy);
    drive(1'b1, $urandom, ID_W'(id), $urandom, $urandom, ordy, 1'b0);
    step();
  endtask

  initial begin
    // Reset state, including zeroed head data.
    repeat (3) @(negedge clk);
    chk("rst_count", 64'(count), 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_ready", 64'(in_ready), 1);
    chk("rst_af", 64'(almost_full), 0);
    chk("rst_data", {out_instr, out_rs1}, 0);
    chk("rst_data2", {32'(out_id), out_rs2}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single entry: one-cycle latency, then pop to empty.
    drive(1'b1, 32'h0000_0057, 4'd3, 32'h11, 32'h22, 1'b0, 1'b0);
    step();
    chk("t1_instr", 64'(out_instr), 64'h57);
    drive(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    step();
    chk("t1_empty", 64'(empty), 1);

    // Fill to full, overflow push ignored, then drain in order.
    for (int i = 0; i < DEPTH + 1; i++) push_id(i, 1'b0);
    chk("t2_full", 64'(count), DEPTH);
    // Full queue with simultaneous push and pop: push refused.
    drive(1'b1, 32'hdead, 4'hf, 32'h1, 32'h2, 1'b1, 1'b0);
    step();
    chk("t3_count", 64'(count), DEPTH - 1);
    drive(1'b1, 32'hbeef, 4'he, 32'h3, 32'h4, 1'b0, 1'b0);
    step();
    chk("t3_refill", 64'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
      step();
    end

    // Steady push+pop at count 2 across several pointer wraps.
    push_id(0, 1'b0);
    push_id(1, 1'b0);
    for (int i = 2; i < 40; i++) push_id(i, 1'b1);
    chk("t4_count", 64'(count), 2);

    // Flush with a concurrent push at count 5.
    drive(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 5; i++) push_id(i, 1'b0);
    drive(1'b1, 32'h1234, 4'h9, 32'h5, 32'h6, 1'b1, 1'b1);
    step();
    chk("t5_count", 64'(count), 0);

`ifdef HP_VPU_IQ_PARITY_EN
    // Corrupt the first RAM entry behind the head; it is flagged when shown.
    begin
      iq_entry_t t;
      push_id(1, 1'b0);
      push_id(2, 1'b0);
      push_id(3, 1'b0);
      dut.u_ram.mem[0][32] = ~dut.u_ram.mem[0][32];
      t = q[1]; t.rs1[0] = ~t.rs1[0]; q[1] = t;
      drive(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
      exp_perr = 1'b1;
      step();
      exp_perr = 1'b0;
      step();
      step();
    end
`endif

    // Randomized traffic with shifting push/pop bias and rare flushes.
    for (int seg = 0; seg < 12; seg++) begin
      int pv, pr;
      pv = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int i = 0; i < 150; i++) begin
        drive(($urandom % 100) < pv, $urandom, ID_W'($urandom), $urandom, $urandom,
              ($urandom % 100) < pr, ($urandom % 64) == 0);
        step();
      end
    end

    // Asynchronous reset mid-operation takes effect without a clock edge.
    for (int i = 0; i < 4; i++) push_id(i, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_count", 64'(count), 0);
    chk("arst_valid", 64'(out_valid), 0);
    chk("arst_empty", 64'(empty), 1);
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    push_id(7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
